// File: rtl/fir_coeff_load_ctrl_if.sv
// Coefficient stream interface for the FIR coefficient reload controller.
// Ports: coeff_valid / coeff_data from source, coeff_ready from controller.
interface fir_coeff_load_ctrl_if #(
   parameter int NB_COEFF = 8
) ();

   logic                coeff_valid;
   logic [NB_COEFF-1:0] coeff_data;
   logic                coeff_ready;

   // Source of the coefficient stream
   modport master (
      output coeff_valid,
      output coeff_data,
      input  coeff_ready
   );

   // Reload controller
   modport slave (
      input  coeff_valid,
      input  coeff_data,
      output coeff_ready
   );

endinterface

// File: rtl/fir_coeff_load_ctrl.sv
// Sequences FIR coefficient reloads: stall, write bank, flush, resume.
// Ports: clock, i_reset, i_enable, i_load_start, coeff_if (stream),
//        o_coeff_we/addr/data (bank write), o_fir_enable, o_fir_flush,
//        o_busy, o_done. All outputs are registered.
module fir_coeff_load_ctrl #(
   parameter int NB_COEFF = 8,
   parameter int N_COEFF  = 6,
   parameter int NB_ADDR  = 3,
   parameter int N_FLUSH  = 6
) (
   input  logic                clock,
   input  logic                i_reset,
   input  logic                i_enable,
   input  logic                i_load_start,
   fir_coeff_load_ctrl_if.slave coeff_if,
   output logic                o_coeff_we,
   output logic [NB_ADDR-1:0]  o_coeff_addr,
   output logic [NB_COEFF-1:0] o_coeff_data,
   output logic                o_fir_enable,
   output logic                o_fir_flush,
   output logic                o_busy,
   output logic                o_done
);

   localparam int NB_FLUSH = (N_FLUSH > 1) ? $clog2(N_FLUSH) : 1;

   localparam logic [NB_ADDR-1:0]  LAST_COEFF = NB_ADDR'(N_COEFF - 1);
   localparam logic [NB_FLUSH-1:0] LAST_FLUSH = NB_FLUSH'(N_FLUSH - 1);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      LOAD  = 2'd1,
      FLUSH = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [NB_ADDR-1:0]  ccnt_q, ccnt_d;
   logic [NB_FLUSH-1:0] fcnt_q, fcnt_d;
   logic                we_q, we_d;
   logic [NB_ADDR-1:0]  addr_q, addr_d;
   logic [NB_COEFF-1:0] data_q, data_d;
   logic                en_q, en_d;
   logic                flush_q, flush_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                ready_q, ready_d;
   logic                hs;

   // Handshake uses the registered ready, so the first LOAD cycle
   // never accepts a word.
   assign hs = ready_q & coeff_if.coeff_valid & (state_q == LOAD);

   always_comb begin
      state_d = state_q;
      ccnt_d  = ccnt_q;
      fcnt_d  = fcnt_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      data_d  = data_q;
      en_d    = en_q;
      flush_d = 1'b0;
      busy_d  = busy_q;
      done_d  = 1'b0;
      ready_d = 1'b0;
      unique case (state_q)
         RUN: begin
            en_d   = i_enable;
            busy_d = 1'b0;
            // A load request wins over the enable request.
            if (i_load_start) begin
               state_d = LOAD;
               ccnt_d  = '0;
               en_d    = 1'b0;
               busy_d  = 1'b1;
            end
         end
         LOAD: begin
            en_d    = 1'b0;
            busy_d  = 1'b1;
            ready_d = 1'b1;
            if (hs) begin
               we_d   = 1'b1;
               addr_d = ccnt_q;
               data_d = coeff_if.coeff_data;
               if (ccnt_q == LAST_COEFF) begin
                  // Last write strobe overlaps the first flush cycle.
                  state_d = FLUSH;
                  fcnt_d  = '0;
                  ready_d = 1'b0;
                  en_d    = 1'b1;
                  flush_d = 1'b1;
               end else begin
                  ccnt_d = ccnt_q + NB_ADDR'(1);
               end
            end
         end
         FLUSH: begin
            en_d    = 1'b1;
            flush_d = 1'b1;
            busy_d  = 1'b1;
            if (fcnt_q == LAST_FLUSH) begin
               state_d = RUN;
               flush_d = 1'b0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               en_d    = i_enable;
            end else begin
               fcnt_d = fcnt_q + NB_FLUSH'(1);
            end
         end
         default: begin
            state_d = RUN;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (i_reset) begin
         state_q <= RUN;
         ccnt_q  <= '0;
         fcnt_q  <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         en_q    <= 1'b0;
         flush_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ccnt_q  <= ccnt_d;
         fcnt_q  <= fcnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         en_q    <= en_d;
         flush_q <= flush_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         ready_q <= ready_d;
      end
   end

   assign coeff_if.coeff_ready = ready_q;
   assign o_coeff_we   = we_q;
   assign o_coeff_addr = addr_q;
   assign o_coeff_data = data_q;
   assign o_fir_enable = en_q;
   assign o_fir_flush  = flush_q;
   assign o_busy       = busy_q;
   assign o_done       = done_q;

endmodule
